// File: rtl/firebird7_in_gate1_tessent_tdr_pkg.sv
// Shared types and sizing helpers for the 19-bit capture/update TDR.
// Latency: n/a (types only).
// Backpressure: n/a.
package firebird7_in_gate1_tessent_tdr_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CAPTURED = 2'd1,
        SHIFTING = 2'd2
    } tdr_state_e;

    // Counter must reach WIDTH+2 (saturation point) without wrapping.
    function automatic int cnt_width(input int width);
        return $clog2(width + 3);
    endfunction

endpackage

// File: rtl/blk_9a3705_if.sv
// IJTAG chain controls plus the functional/mux-side data of the TDR.
// Latency: n/a (wiring only).
// Backpressure: none; IJTAG enables are unconditional strobes.
interface blk_9a3705_if #(
    parameter int WIDTH = 19
);
    logic             ijtag_sel;
    logic             ijtag_ce;
    logic             ijtag_se;
    logic             ijtag_ue;
    logic             ijtag_si;
    logic             ijtag_so;
    logic [WIDTH-1:0] functional_data_in;
    logic [WIDTH-1:0] ijtag_data_out;
    logic             ijtag_select;
    logic             update_err;

    modport master (
        output ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si, functional_data_in,
        input  ijtag_so, ijtag_data_out, ijtag_select, update_err
    );

    modport slave (
        input  ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si, functional_data_in,
        output ijtag_so, ijtag_data_out, ijtag_select, update_err
    );
endinterface

// File: rtl/blk_9a3705.sv
// Capture/shift/update test data register driving the 19-bit functional/IJTAG mux.
// Latency: update outputs 1 cycle after accepted ue; so follows each shift by 1 cycle.
// Backpressure: none; a refused guarded update pulses update_err for one cycle.
module blk_9a3705
    import firebird7_in_gate1_tessent_tdr_pkg::*;
#(
    parameter int               WIDTH        = 19,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
    parameter bit               UPDATE_GUARD = 1'b1
) (
    input  logic          ijtag_tck,
    input  logic          ijtag_reset,
    blk_9a3705_if.slave   tdr
);

    localparam int               CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]    CNT_FULL = CW'(WIDTH + 1);
    localparam logic [CW-1:0]    CNT_SAT  = CW'(WIDTH + 2);

    tdr_state_e       state;
    tdr_state_e       state_nxt;
    logic [CW-1:0]    shift_cnt;
    logic [WIDTH:0]   shift_reg;
    logic [WIDTH:0]   update_reg;
    logic             update_err_q;

    logic             do_capture;
    logic             do_shift;
    logic             do_update;
    logic             update_ok;
    logic             update_bad;

    // State register
    always_ff @(posedge ijtag_tck) begin
        if (!ijtag_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: ce beats se beats ue; nothing moves while deselected.
    always_comb begin
        state_nxt = state;
        if (do_capture) begin
            state_nxt = CAPTURED;
        end else if (do_shift) begin
            state_nxt = SHIFTING;
        end else if (do_update) begin
            state_nxt = IDLE;
        end
    end

    // Operation decode
    always_comb begin
        do_capture = tdr.ijtag_sel & tdr.ijtag_ce;
        do_shift   = tdr.ijtag_sel & ~tdr.ijtag_ce & tdr.ijtag_se;
        do_update  = tdr.ijtag_sel & ~tdr.ijtag_ce & ~tdr.ijtag_se & tdr.ijtag_ue;
        // A saturated count never equals CNT_FULL, so over-long scans are refused too.
        update_ok  = do_update &
                     (!UPDATE_GUARD || ((state == SHIFTING) && (shift_cnt == CNT_FULL)));
        update_bad = do_update & ~update_ok;
    end

    // Datapath: shift chain, counter, update register, error pulse
    always_ff @(posedge ijtag_tck) begin
        if (!ijtag_reset) begin
            shift_reg    <= '0;
            shift_cnt    <= '0;
            update_reg   <= {1'b0, RESET_VALUE};
            update_err_q <= 1'b0;
        end else begin
            update_err_q <= update_bad;
            if (do_capture) begin
                shift_reg <= {update_reg[WIDTH], tdr.functional_data_in};
                shift_cnt <= '0;
            end else if (do_shift) begin
                shift_reg <= {tdr.ijtag_si, shift_reg[WIDTH:1]};
                if (shift_cnt != CNT_SAT) begin
                    shift_cnt <= shift_cnt + 1'b1;
                end
            end else if (do_update) begin
                shift_cnt <= '0;
                if (update_ok) begin
                    update_reg <= shift_reg;
                end
            end
        end
    end

    assign tdr.ijtag_so       = shift_reg[0];
    assign tdr.ijtag_data_out = update_reg[WIDTH-1:0];
    assign tdr.ijtag_select   = update_reg[WIDTH];
    assign tdr.update_err     = update_err_q;

endmodule

// File: tb/tb_blk_9a3705.sv
// Directed bench for the 19-bit capture/update TDR with hand-computed expectations.
module tb_blk_9a3705;
    localparam int WIDTH = 19;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    blk_9a3705_if #(.WIDTH(WIDTH)) bus ();

    blk_9a3705 #(.WIDTH(WIDTH), .RESET_VALUE('0), .UPDATE_GUARD(1'b1)) dut (
        .ijtag_tck   (clk),
        .ijtag_reset (rst_n),
        .tdr         (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ijtag_ce = 1'b0;
        bus.ijtag_se = 1'b0;
        bus.ijtag_ue = 1'b0;
        bus.ijtag_si = 1'b0;
    endtask

    task automatic do_capture(input logic [WIDTH-1:0] d);
        bus.functional_data_in = d;
        bus.ijtag_sel = 1'b1;
        bus.ijtag_ce  = 1'b1;
        tick();
        bus.ijtag_ce  = 1'b0;
    endtask

    task automatic do_shift(input logic b);
        bus.ijtag_sel = 1'b1;
        bus.ijtag_se  = 1'b1;
        bus.ijtag_si  = b;
        tick();
        bus.ijtag_se  = 1'b0;
        bus.ijtag_si  = 1'b0;
    endtask

    task automatic do_update();
        bus.ijtag_sel = 1'b1;
        bus.ijtag_ue  = 1'b1;
        tick();
        bus.ijtag_ue  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        repeat (5) tick();
        total++; if (bus.ijtag_data_out !== 19'h00000) begin bad++; $display("FAIL reset_data got=%h want=00000", bus.ijtag_data_out); end
        total++; if (bus.ijtag_select !== 1'b0) begin bad++; $display("FAIL reset_select got=%b want=0", bus.ijtag_select); end
        total++; if (bus.ijtag_so !== 1'b0) begin bad++; $display("FAIL reset_so got=%b want=0", bus.ijtag_so); end
        total++; if (bus.update_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", bus.update_err); end
    endtask

    task automatic test_capture_shift();
        logic [WIDTH:0] exp_bits;
        exp_bits = {1'b0, 19'h5A5A5};
        do_capture(19'h5A5A5);
        for (int i = 0; i < WIDTH + 1; i++) begin
            total++;
            if (bus.ijtag_so !== exp_bits[i]) begin
                bad++; $display("FAIL cap_so bit=%0d got=%b want=%b", i, bus.ijtag_so, exp_bits[i]);
            end
            do_shift(1'b0);
        end
        total++; if (bus.ijtag_so !== 1'b0) begin bad++; $display("FAIL cap_so_drained got=%b want=0", bus.ijtag_so); end
    endtask

    task automatic test_update();
        logic [WIDTH:0] pat;
        pat = {1'b1, 19'h7FFFF};
        do_capture(19'h00000);
        for (int i = 0; i < WIDTH + 1; i++) do_shift(pat[i]);
        total++; if (bus.ijtag_data_out !== 19'h00000) begin bad++; $display("FAIL upd_pre_data got=%h want=00000", bus.ijtag_data_out); end
        do_update();
        total++; if (bus.ijtag_data_out !== 19'h7FFFF) begin bad++; $display("FAIL upd_data got=%h want=7ffff", bus.ijtag_data_out); end
        total++; if (bus.ijtag_select !== 1'b1) begin bad++; $display("FAIL upd_select got=%b want=1", bus.ijtag_select); end
        total++; if (bus.update_err !== 1'b0) begin bad++; $display("FAIL upd_err got=%b want=0", bus.update_err); end
    endtask

    task automatic test_short_long();
        int lens [2];
        lens[0] = WIDTH;
        lens[1] = WIDTH + 2;
        for (int k = 0; k < 2; k++) begin
            do_capture(19'h0F0F0);
            for (int i = 0; i < lens[k]; i++) do_shift(1'b0);
            do_update();
            total++; if (bus.ijtag_data_out !== 19'h7FFFF) begin bad++; $display("FAIL guard_data len=%0d got=%h want=7ffff", lens[k], bus.ijtag_data_out); end
            total++; if (bus.ijtag_select !== 1'b1) begin bad++; $display("FAIL guard_select len=%0d got=%b want=1", lens[k], bus.ijtag_select); end
            total++; if (bus.update_err !== 1'b1) begin bad++; $display("FAIL guard_err len=%0d got=%b want=1", lens[k], bus.update_err); end
            tick();
            total++; if (bus.update_err !== 1'b0) begin bad++; $display("FAIL guard_err_pulse len=%0d got=%b want=0", lens[k], bus.update_err); end
        end
    endtask

    task automatic test_priority_sel();
        logic [WIDTH:0] exp_bits;
        exp_bits = {1'b1, 19'h12345};
        bus.functional_data_in = 19'h12345;
        bus.ijtag_sel = 1'b1;
        bus.ijtag_ce  = 1'b1;
        bus.ijtag_se  = 1'b1;
        bus.ijtag_ue  = 1'b1;
        bus.ijtag_si  = 1'b0;
        tick();
        idle_inputs();
        total++; if (bus.ijtag_so !== 1'b1) begin bad++; $display("FAIL prio_so got=%b want=1", bus.ijtag_so); end
        total++; if (bus.ijtag_data_out !== 19'h7FFFF) begin bad++; $display("FAIL prio_data got=%h want=7ffff", bus.ijtag_data_out); end
        total++; if (bus.update_err !== 1'b0) begin bad++; $display("FAIL prio_err got=%b want=0", bus.update_err); end
        bus.ijtag_sel = 1'b0;
        bus.ijtag_se  = 1'b1;
        repeat (10) tick();
        bus.ijtag_se  = 1'b0;
        total++; if (bus.ijtag_so !== 1'b1) begin bad++; $display("FAIL desel_so got=%b want=1", bus.ijtag_so); end
        for (int i = 0; i < WIDTH + 1; i++) begin
            total++;
            if (bus.ijtag_so !== exp_bits[i]) begin
                bad++; $display("FAIL desel_hold_so bit=%0d got=%b want=%b", i, bus.ijtag_so, exp_bits[i]);
            end
            do_shift(1'b0);
        end
        do_update();
        total++; if (bus.ijtag_data_out !== 19'h00000) begin bad++; $display("FAIL prio_cnt_data got=%h want=00000", bus.ijtag_data_out); end
        total++; if (bus.ijtag_select !== 1'b0) begin bad++; $display("FAIL prio_cnt_select got=%b want=0", bus.ijtag_select); end
        total++; if (bus.update_err !== 1'b0) begin bad++; $display("FAIL prio_cnt_err got=%b want=0", bus.update_err); end
    endtask

    task automatic test_reset_mid_shift();
        logic [WIDTH:0] pat;
        pat = {1'b0, 19'h2C3A1};
        do_capture(19'h7FFFF);
        for (int i = 0; i < 10; i++) do_shift(1'b1);
        bus.ijtag_sel = 1'b1;
        bus.ijtag_se  = 1'b1;
        bus.ijtag_si  = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        idle_inputs();
        total++; if (bus.ijtag_so !== 1'b0) begin bad++; $display("FAIL rst_mid_so got=%b want=0", bus.ijtag_so); end
        total++; if (bus.ijtag_data_out !== 19'h00000) begin bad++; $display("FAIL rst_mid_data got=%h want=00000", bus.ijtag_data_out); end
        for (int i = 0; i < WIDTH + 1; i++) do_shift(pat[i]);
        do_update();
        total++; if (bus.ijtag_data_out !== 19'h2C3A1) begin bad++; $display("FAIL rst_mid_upd_data got=%h want=2c3a1", bus.ijtag_data_out); end
        total++; if (bus.ijtag_select !== 1'b0) begin bad++; $display("FAIL rst_mid_upd_select got=%b want=0", bus.ijtag_select); end
        total++; if (bus.update_err !== 1'b0) begin bad++; $display("FAIL rst_mid_upd_err got=%b want=0", bus.update_err); end
    endtask

    initial begin
        bus.ijtag_sel = 1'b0;
        bus.functional_data_in = '0;
        idle_inputs();
        test_reset();
        test_capture_shift();
        test_update();
        test_short_long();
        test_priority_sel();
        test_reset_mid_shift();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
